// File: rtl/seq_window_checker.sv
// Multi-channel checker for trigger -> windowed response -> follow-up handshakes.
// Each channel reports pass/fail pulses and a held cause code; aggregate counters saturate.
module seq_window_checker #(
  parameter int NUM_CH  = 4,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 5,
  parameter int GAP     = 1,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_CH-1:0]     trig,
  input  logic [NUM_CH-1:0]     resp,
  input  logic [NUM_CH-1:0]     follow,
  input  logic [NUM_CH-1:0]     ce,
  output logic [NUM_CH-1:0]     busy,
  output logic [NUM_CH-1:0]     pass,
  output logic [NUM_CH-1:0]     fail,
  output logic [2*NUM_CH-1:0]   fail_code,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt
);

  // state  | meaning
  // IDLE   | waiting for a rising trigger
  // WAIT_R | counting offset from trigger, looking for a response rise
  // WAIT_F | counting offset from response, follow-up due at GAP
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT_R = 2'd1;
  localparam logic [1:0] S_WAIT_F = 2'd2;

  localparam logic [7:0] MIN8 = 8'(MIN_DLY);
  localparam logic [7:0] MAX8 = 8'(MAX_DLY);
  localparam logic [7:0] GAP8 = 8'(GAP);

  localparam int PW = $clog2(NUM_CH + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [SW-1:0] CNT_MAX = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [NUM_CH-1:0]   trig_q, resp_q, follow_q;
  logic [NUM_CH-1:0]   trig_rise, resp_rise, follow_rise;
  logic [NUM_CH-1:0]   pass_d, fail_d;

  assign trig_rise   = trig & ~trig_q;
  assign resp_rise   = resp & ~resp_q;
  assign follow_rise = follow & ~follow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q   <= '0;
      resp_q   <= '0;
      follow_q <= '0;
    end else begin
      trig_q   <= trig;
      resp_q   <= resp;
      follow_q <= follow;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0] st_q, st_d;
    logic [7:0] off_q, off_d, off_inc;
    logic [1:0] code_q, code_d;
    logic       p_d, f_d;

    always_comb begin
      st_d    = st_q;
      off_d   = 8'd0;
      code_d  = 2'b00;
      p_d     = 1'b0;
      f_d     = 1'b0;
      off_inc = off_q + 8'd1;
      // en low abandons the sequence silently; ce low outranks every other outcome
      if (!en) begin
        st_d = S_IDLE;
      end else begin
        case (st_q)
          S_IDLE: begin
            if (trig_rise[i]) begin
              if (!ce[i]) begin
                f_d    = 1'b1;
                code_d = 2'b01;
              end else begin
                st_d = S_WAIT_R;
              end
            end
          end
          S_WAIT_R: begin
            off_d = off_inc;
            if (!ce[i]) begin
              f_d    = 1'b1;
              code_d = 2'b01;
              st_d   = S_IDLE;
            end else if (resp_rise[i] && off_inc >= MIN8 && off_inc <= MAX8) begin
              st_d  = S_WAIT_F;
              off_d = 8'd0;
            end else if (off_inc >= MAX8) begin
              f_d    = 1'b1;
              code_d = 2'b10;
              st_d   = S_IDLE;
            end
          end
          S_WAIT_F: begin
            off_d = off_inc;
            if (!ce[i]) begin
              f_d    = 1'b1;
              code_d = 2'b01;
              st_d   = S_IDLE;
            end else if (off_inc == GAP8) begin
              st_d = S_IDLE;
              if (follow_rise[i]) begin
                p_d = 1'b1;
              end else begin
                f_d    = 1'b1;
                code_d = 2'b11;
              end
            end
          end
          default: st_d = S_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q   <= S_IDLE;
        off_q  <= 8'd0;
        code_q <= 2'b00;
      end else begin
        st_q  <= st_d;
        off_q <= off_d;
        if (f_d) code_q <= code_d;
      end
    end

    assign busy[i]            = (st_q != S_IDLE);
    assign pass_d[i]          = p_d;
    assign fail_d[i]          = f_d;
    assign fail_code[2*i +: 2] = code_q;
  end

  function automatic logic [SW-1:0] popcnt(input logic [NUM_CH-1:0] v);
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < NUM_CH; k++) s = s + SW'(v[k]);
    return s;
  endfunction

  logic [SW-1:0] pass_sum, fail_sum;
  assign pass_sum = {{(SW-CNT_W){1'b0}}, pass_cnt} + popcnt(pass_d);
  assign fail_sum = {{(SW-CNT_W){1'b0}}, fail_cnt} + popcnt(fail_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass     <= '0;
      fail     <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      pass     <= pass_d;
      fail     <= fail_d;
      pass_cnt <= (pass_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : pass_sum[CNT_W-1:0];
      fail_cnt <= (fail_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : fail_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_seq_window_checker.sv
// Bench for seq_window_checker: directed table, hand sequences and random stimulus
// checked against a cycle-stamp reference model, on a GAP=1 and a GAP=2/CNT_W=2 instance.
module tb_seq_window_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] trig = '0, resp = '0, follow = '0, ce = '0;

  logic [3:0] busy0, pass0, fail0;
  logic [7:0] code0, pc0, fc0;
  logic [3:0] busy1, pass1, fail1;
  logic [7:0] code1;
  logic [1:0] pc1, fc1;

  always #5 clk = ~clk;

  seq_window_checker dut0 (
    .clk(clk), .rst(rst), .en(en), .trig(trig), .resp(resp), .follow(follow), .ce(ce),
    .busy(busy0), .pass(pass0), .fail(fail0), .fail_code(code0),
    .pass_cnt(pc0), .fail_cnt(fc0)
  );

  seq_window_checker #(.GAP(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .en(en), .trig(trig), .resp(resp), .follow(follow), .ce(ce),
    .busy(busy1), .pass(pass1), .fail(fail1), .fail_code(code1),
    .pass_cnt(pc1), .fail_cnt(fc1)
  );

  int total = 0;
  int bad   = 0;

  localparam int MIN_D = 1;
  localparam int MAX_D = 5;

  // reference model: phase per channel plus the cycle number at which it started
  int         cyc = 0;
  int         m_ph [2][4];
  int         m_t0 [2][4];
  logic [3:0] p_trig, p_resp, p_follow;
  logic [3:0] e_busy [2];
  logic [3:0] e_pass [2];
  logic [3:0] e_fail [2];
  logic [7:0] e_code [2];
  int         e_pc [2];
  int         e_fc [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 4; ch++) begin
        m_ph[d][ch] = 0;
        m_t0[d][ch] = 0;
      end
      e_busy[d] = '0; e_pass[d] = '0; e_fail[d] = '0; e_code[d] = '0;
      e_pc[d] = 0; e_fc[d] = 0;
    end
    p_trig = '0; p_resp = '0; p_follow = '0;
  endtask

  task automatic model_tick();
    int gap, cmax, off, code;
    logic [3:0] pv, fv;
    logic rt, rr, rf;
    for (int d = 0; d < 2; d++) begin
      gap  = (d == 0) ? 1 : 2;
      cmax = (d == 0) ? 255 : 3;
      pv = '0; fv = '0;
      for (int ch = 0; ch < 4; ch++) begin
        rt = trig[ch] & ~p_trig[ch];
        rr = resp[ch] & ~p_resp[ch];
        rf = follow[ch] & ~p_follow[ch];
        off  = cyc - m_t0[d][ch];
        code = 0;
        if (!en) begin
          m_ph[d][ch] = 0;
        end else if (m_ph[d][ch] == 0) begin
          if (rt) begin
            if (!ce[ch]) code = 1;
            else begin m_ph[d][ch] = 1; m_t0[d][ch] = cyc; end
          end
        end else if (!ce[ch]) begin
          code = 1;
        end else if (m_ph[d][ch] == 1) begin
          if (rr && off >= MIN_D && off <= MAX_D) begin
            m_ph[d][ch] = 2; m_t0[d][ch] = cyc;
          end else if (off >= MAX_D) code = 2;
        end else if (off == gap) begin
          if (rf) begin pv[ch] = 1'b1; m_ph[d][ch] = 0; end
          else code = 3;
        end
        if (code != 0) begin
          fv[ch] = 1'b1;
          e_code[d][2*ch +: 2] = 2'(code);
          m_ph[d][ch] = 0;
        end
        e_busy[d][ch] = (m_ph[d][ch] != 0);
      end
      e_pass[d] = pv;
      e_fail[d] = fv;
      e_pc[d] = (e_pc[d] + $countones(pv) > cmax) ? cmax : e_pc[d] + $countones(pv);
      e_fc[d] = (e_fc[d] + $countones(fv) > cmax) ? cmax : e_fc[d] + $countones(fv);
    end
    p_trig = trig; p_resp = resp; p_follow = follow;
    cyc++;
  endtask

  task automatic check_all(input string nm);
    chk({nm, " busy0"}, busy0, e_busy[0]);
    chk({nm, " pass0"}, pass0, e_pass[0]);
    chk({nm, " fail0"}, fail0, e_fail[0]);
    chk({nm, " code0"}, code0, e_code[0]);
    chk({nm, " pass_cnt0"}, pc0, e_pc[0]);
    chk({nm, " fail_cnt0"}, fc0, e_fc[0]);
    chk({nm, " busy1"}, busy1, e_busy[1]);
    chk({nm, " pass1"}, pass1, e_pass[1]);
    chk({nm, " fail1"}, fail1, e_fail[1]);
    chk({nm, " code1"}, code1, e_code[1]);
    chk({nm, " pass_cnt1"}, pc1, e_pc[1]);
    chk({nm, " fail_cnt1"}, fc1, e_fc[1]);
  endtask

  // inputs are changed at the negedge; model ticks on posedge, outputs checked at next negedge
  task automatic step(input string nm);
    @(posedge clk);
    model_tick();
    @(negedge clk);
    check_all(nm);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    trig = '0; resp = '0; follow = '0; ce = '1;
    repeat (n) step("idle");
  endtask

  typedef struct packed {
    logic t, r, f, c;
    logic eb, ep, ef;
    logic [1:0] ec;
  } vec_t;

  // channel 0 only, en=1, other channels quiet with ce=1; expectations are for the GAP=1 instance
  vec_t tbl [24] = '{
    '{0,0,0,1, 0,0,0,2'b00},
    '{1,0,0,1, 1,0,0,2'b00},
    '{0,0,0,1, 1,0,0,2'b00},
    '{0,1,0,1, 1,0,0,2'b00},
    '{0,1,1,1, 0,1,0,2'b00},
    '{0,0,0,1, 0,0,0,2'b00},
    '{1,0,0,1, 1,0,0,2'b00},
    '{0,0,0,1, 1,0,0,2'b00},
    '{0,0,0,0, 0,0,1,2'b01},
    '{0,0,0,1, 0,0,0,2'b01},
    '{1,0,0,1, 1,0,0,2'b01},
    '{0,0,0,1, 1,0,0,2'b01},
    '{0,0,0,1, 1,0,0,2'b01},
    '{0,0,0,1, 1,0,0,2'b01},
    '{0,0,0,1, 1,0,0,2'b01},
    '{0,0,0,1, 0,0,1,2'b10},
    '{0,1,0,1, 0,0,0,2'b10},
    '{0,0,0,1, 0,0,0,2'b10},
    '{1,0,0,1, 1,0,0,2'b10},
    '{0,0,0,1, 1,0,0,2'b10},
    '{1,0,0,1, 1,0,0,2'b10},
    '{1,1,0,1, 1,0,0,2'b10},
    '{1,0,1,1, 0,1,0,2'b10},
    '{0,0,0,1, 0,0,0,2'b10}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pc_before;
    @(negedge clk);
    apply_reset();
    en = 1'b1;

    for (int i = 0; i < 24; i++) begin
      trig   = {3'b000, tbl[i].t};
      resp   = {3'b000, tbl[i].r};
      follow = {3'b000, tbl[i].f};
      ce     = {3'b111, tbl[i].c};
      step("tbl");
      chk("tbl busy", busy0[0], tbl[i].eb);
      chk("tbl pass", pass0[0], tbl[i].ep);
      chk("tbl fail", fail0[0], tbl[i].ef);
      chk("tbl code", code0[1:0], tbl[i].ec);
    end
    chk("tbl pass_cnt", pc0, 2);
    chk("tbl fail_cnt", fc0, 2);
    idle(3);

    // channels 0 and 2 pass together on the GAP=1 instance
    pc_before = e_pc[0];
    trig = 4'b0101; step("sim trig");
    trig = '0; resp = 4'b0101; step("sim resp");
    resp = '0; follow = 4'b0101; step("sim follow");
    chk("sim pass vec", pass0, 4'b0101);
    chk("sim pass_cnt", pc0, pc_before + 2);
    idle(4);

    // GAP=2 instance: two-channel passes repeated until the 2-bit counter saturates
    for (int k = 0; k < 3; k++) begin
      trig = 4'b0101; step("sat trig");
      trig = '0; resp = 4'b0101; step("sat resp");
      resp = '0; step("sat off1");
      follow = 4'b0101; step("sat follow");
      chk("sat pass vec1", pass1, 4'b0101);
      idle(3);
    end
    chk("sat pass_cnt1", pc1, 3);

    // GAP=2 instance: follow one cycle late fails with code 11 at offset 2
    trig = 4'b0001; step("late trig");
    trig = '0; resp = 4'b0001; step("late resp");
    resp = '0; step("late off1");
    step("late off2");
    chk("late fail1", fail1[0], 1'b1);
    chk("late code1", code1[1:0], 2'b11);
    follow = 4'b0001; step("late follow");
    chk("late no pass1", pass1[0], 1'b0);
    idle(3);

    // reset in WAIT_F clears immediately and produces no pulse afterwards
    trig = 4'b0001; step("rw trig");
    trig = '0; resp = 4'b0001; step("rw resp");
    chk("rw busy before rst", busy0[0], 1'b1);
    resp = '0;
    #2;
    apply_reset();
    chk("rw pass after rst", pass0, 4'b0000);
    idle(4);

    // trigger held high across reset release counts as a rise on the first edge
    trig = 4'b0010;
    @(negedge clk);
    apply_reset();
    step("rel rise");
    chk("rel busy", busy0[1], 1'b1);
    idle(8);

    for (int n = 0; n < 4000; n++) begin
      en = ($urandom_range(63) != 0);
      for (int ch = 0; ch < 4; ch++) begin
        ce[ch]     = ($urandom_range(31) != 0);
        trig[ch]   = ($urandom_range(3) == 0);
        resp[ch]   = ($urandom_range(2) == 0);
        follow[ch] = ($urandom_range(1) == 0);
      end
      if ($urandom_range(499) == 0) begin
        #2;
        apply_reset();
      end else begin
        step("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_window_checker.md
Name: seq_window_checker

Overview:
- Synthesizable, multi-channel hardware checker for the trigger -> windowed response -> follow-up handshake rule: after a trigger, the response must rise within a delay window, and the follow-up must rise a fixed gap later, with the enable held high the whole time.
- Runs in-system alongside the monitored logic. Reports per-channel pass/fail pulses, a failure cause code and saturating aggregate counters.

Parameters:
- NUM_CH, 4, number of independent monitored channels
- MIN_DLY, 1, earliest cycle offset after trigger at which a response rise is accepted (>=1)
- MAX_DLY, 5, latest accepted response offset (>=MIN_DLY, <=255)
- GAP, 1, exact cycle offset from response rise to follow-up rise (>=1, <=255)
- CNT_W, 8, width of the pass and fail counters

Ports:
- clk  in  1  system clock, all sampling on posedge
- rst  in  1  asynchronous active-high reset
- en  in  1  global enable; low forces all channels to IDLE, no new starts
- trig  in  NUM_CH  per-channel trigger (a)
- resp  in  NUM_CH  per-channel response (c)
- follow  in  NUM_CH  per-channel follow-up (b)
- ce  in  NUM_CH  per-channel qualifier that must stay high throughout
- busy  out  NUM_CH  channel is tracking a sequence
- pass  out  NUM_CH  one-cycle pass pulse
- fail  out  NUM_CH  one-cycle fail pulse
- fail_code  out  2*NUM_CH  per-channel cause, held until the next fail on that channel: 01 = ce dropped, 10 = resp timeout, 11 = follow missing
- pass_cnt  out  CNT_W  total passes, all channels, saturating
- fail_cnt  out  CNT_W  total fails, all channels, saturating

Behaviour:
- Reset: all outputs 0, all channels IDLE, edge-detect history registers 0.
- Edge detection: rose(x) = x sampled high on this edge and low on the previous edge. Same semantics as a $rose sample.
- Per-channel FSM with states IDLE, WAIT_R, WAIT_F. An offset counter of 8 bits is cleared on entry to each state.
- IDLE, on rose(trig) with en=1:
  - if ce=0 on that same edge, fail with code 01; stay IDLE;
  - otherwise go to WAIT_R with offset 0.
- WAIT_R: offset increments each edge.
  - ce=0 -> fail 01.
  - rose(resp) at offset in [MIN_DLY, MAX_DLY] -> WAIT_F.
  - rose(resp) below MIN_DLY is ignored.
  - No accepted rise by offset MAX_DLY -> fail 10, decided on the offset-MAX_DLY edge.
- WAIT_F: offset increments each edge.
  - ce=0 -> fail 01.
  - rose(follow) exactly at offset GAP -> pass.
  - Otherwise fail 11, decided at offset GAP. Rises before GAP are ignored.
- Matching semantics: first accepted response rise is committed (first-match); later rises are not explored as alternative threads.
- Priority on one edge: ce=0 beats every other event; a timeout or follow check is never reported together with 01.
- Overlap: rose(trig) while busy is ignored; there is no re-arm. A trigger on the same edge that completes a sequence is also ignored; the channel returns to IDLE and needs a fresh rising edge.
- Timing: pass and fail are registered. Each is high for exactly the one cycle after its deciding edge. busy is high from the edge after the trigger until the deciding edge.
- Counters: add the popcount of channels passing (or failing) on each deciding edge, saturating at 2^CNT_W-1.
- en falling mid-sequence: the channel returns to IDLE with no pass or fail. Counters are held.
- Channels are fully independent; simultaneous decisions on different channels are all reported.
- rst asserted mid-sequence: immediate return to the reset state. The history registers clear, so an input that is high when rst releases counts as a rise on the first edge.

Test Plan:
- Clock period 10, edges at 5, 15, 25...; ch0: ce=1 over 15..75, trig high 20..30, resp high 40..50, follow high 49..59 -> trig rise at edge 25, resp at offset 2, follow at GAP 1 -> pass[0] high 55..65, pass_cnt=1, fail_cnt=0.
- Same as the first, but ce drops to 0 at 42 -> fail[0] after edge 45, fail_code[1:0]=01, no pass.
- Trig rise with no resp activity -> fail 10 decided at offset 5 (edge 75), fail_cnt=1; a resp rise at offset 6 is ignored.
- Resp rise at offset 1, follow rise at offset 3 (GAP 2 missed by one) -> fail code 11 on the offset-2 edge after resp.
- Channels 0 and 2 both pass on the same edge -> pass=4'b0101, pass_cnt increments by 2. With CNT_W=2, repeated passes saturate at 3.
- Second trig rise during WAIT_R is ignored, busy stays high; assert rst mid-WAIT_F -> all outputs 0 immediately, no pulse after release.
